// File: rtl/namco_pkg.sv
// Shared encodings for the parametrised Namco 175/340/163 mapper core:
// mode values, CPU register decode masks/values and save-state indices.
package namco_pkg;

  typedef enum logic [1:0] {
    MODE_175 = 2'd0,
    MODE_340 = 2'd1,
    MODE_163 = 2'd2,
    MODE_RSV = 2'd3
  } mode_e;

  localparam logic [15:0] MASK_PAGE   = 16'hF800;
  localparam logic [15:0] MASK_CHR    = 16'hC000;
  localparam logic [15:0] ADDR_IRQ_LO = 16'h5000;
  localparam logic [15:0] ADDR_IRQ_HI = 16'h5800;
  localparam logic [15:0] ADDR_CHR    = 16'h8000;
  localparam logic [15:0] ADDR_RAM_ON = 16'hC000;
  localparam logic [15:0] ADDR_PRG0   = 16'hE000;
  localparam logic [15:0] ADDR_PRG1   = 16'hE800;
  localparam logic [15:0] ADDR_PRG2   = 16'hF000;
  localparam logic [15:0] ADDR_WP     = 16'hF800;

  localparam logic [7:0] SS_PRG0   = 8'd8;
  localparam logic [7:0] SS_PRG1   = 8'd9;
  localparam logic [7:0] SS_PRG2   = 8'd10;
  localparam logic [7:0] SS_RAM_ON = 8'd11;
  localparam logic [7:0] SS_WP     = 8'd12;
  localparam logic [7:0] SS_CNT_LO = 8'd13;
  localparam logic [7:0] SS_CNT_HI = 8'd14;
  localparam logic [7:0] SS_IRQ    = 8'd15;

  function automatic logic addr_hit(input logic [15:0] addr, input logic [15:0] mask,
                                    input logic [15:0] val);
    return (addr & mask) == val;
  endfunction

endpackage

// File: rtl/namco_irq_cnt.sv
// 163-style CPU-cycle IRQ counter: saturating up-counter with enable, sticky
// irq flag and readback bytes. State advances on the falling edge of m2.
module namco_irq_cnt
  import namco_pkg::*;
#(
  parameter int IRQ_W = 15
) (
  input  logic       m2,
  input  logic       map_rst,
  input  logic       active,
  input  logic       frz,
  input  logic       wr_lo,
  input  logic       wr_hi,
  input  logic       ld_lo,
  input  logic       ld_hi,
  input  logic       ld_irq,
  input  logic [7:0] dat,
  output logic [7:0] cnt_lo,
  output logic [7:0] cnt_hi,
  output logic       irq
);

  localparam int HI_W = IRQ_W - 8;

  logic [IRQ_W-1:0] cnt;
  logic [IRQ_W-1:0] cnt_inc;
  logic             en;

  assign cnt_inc = cnt + IRQ_W'(1);

  always_ff @(negedge m2) begin
    if (map_rst) begin
      cnt <= '0;
      en  <= 1'b0;
      irq <= 1'b0;
    end else if (ld_lo || ld_hi || ld_irq) begin
      if (ld_lo) cnt[7:0] <= dat;
      if (ld_hi) begin
        cnt[IRQ_W-1:8] <= dat[HI_W-1:0];
        en             <= dat[7];
      end
      if (ld_irq) irq <= dat[0];
    end else if (!active) begin
      irq <= 1'b0;
    end else if (!frz) begin
      // a CPU write in the same cycle replaces the increment entirely
      if (wr_lo) begin
        cnt[7:0] <= dat;
        irq      <= 1'b0;
      end else if (wr_hi) begin
        cnt[IRQ_W-1:8] <= dat[HI_W-1:0];
        en             <= dat[7];
        irq            <= 1'b0;
      end else if (en && !(&cnt)) begin
        cnt <= cnt_inc;
        if (&cnt_inc) irq <= 1'b1;
      end
    end
  end

  always_comb begin
    cnt_lo              = cnt[7:0];
    cnt_hi              = 8'h00;
    cnt_hi[HI_W-1:0]    = cnt[IRQ_W-1:8];
    cnt_hi[7]           = en;
  end

endmodule

// File: rtl/map_namco_n1xx.sv
// Namco 175/340/163 mapper core: bank registers, PRG/CHR/nametable mapping,
// PRG-RAM strobes and IRQ. Save-state access is built when MAP_NAMCO_SS_EN is defined.
module map_namco_n1xx
  import namco_pkg::*;
#(
  parameter int PRG_BW    = 6,
  parameter int CHR_BW    = 8,
  parameter int CHR_BANKS = 8,
  parameter int IRQ_W     = 15
) (
  input  logic                m2,
  input  logic                map_rst,
  input  logic [1:0]          mode,
  input  logic                cfg_mir_v,
  input  logic [15:0]         cpu_addr,
  input  logic [7:0]          cpu_dat,
  input  logic                cpu_rw,
  input  logic [13:0]         ppu_addr,
  output logic [PRG_BW+12:0]  prg_addr,
  output logic [CHR_BW+9:0]   chr_addr,
  output logic                ciram_a10,
  output logic                ciram_ce,
  output logic                rom_ce,
  output logic                ram_ce,
  output logic                ram_we,
  output logic                reg_oe,
  output logic [7:0]          reg_dout,
  output logic                irq,
  input  logic                ss_act,
  input  logic                ss_we,
  input  logic [7:0]          ss_addr,
  output logic [7:0]          ss_rdat
);

  localparam int CHR_IW = $clog2(CHR_BANKS);
  localparam logic [7:0] CHR_N = 8'(CHR_BANKS);

  mode_e md;
  logic  is_175, is_340, is_163;
  assign md     = mode_e'(mode);
  assign is_340 = (md == MODE_340);
  assign is_163 = (md == MODE_163);
  assign is_175 = (md == MODE_175) || (md == MODE_RSV);

  logic [CHR_BW-1:0] chr_bank [CHR_BANKS];
  logic [7:0]        prg_bank [3];
  logic              prg_ram_on;
  logic [3:0]        wp;

  logic frz, ss_wr;
`ifdef MAP_NAMCO_SS_EN
  assign frz   = ss_act;
  assign ss_wr = ss_act && ss_we;
`else
  assign frz   = 1'b0;
  assign ss_wr = 1'b0;
  logic unused_ss;
  assign unused_ss = ^{ss_act, ss_we};
`endif

  logic cpu_wr;
  logic wr_chr, wr_prg0, wr_prg1, wr_prg2, wr_ram_on, wr_wp, wr_lo, wr_hi;
  logic hit_lo, hit_hi;
  assign cpu_wr    = !cpu_rw && !frz;
  assign hit_lo    = addr_hit(cpu_addr, MASK_PAGE, ADDR_IRQ_LO);
  assign hit_hi    = addr_hit(cpu_addr, MASK_PAGE, ADDR_IRQ_HI);
  assign wr_chr    = cpu_wr && addr_hit(cpu_addr, MASK_CHR, ADDR_CHR);
  assign wr_prg0   = cpu_wr && addr_hit(cpu_addr, MASK_PAGE, ADDR_PRG0);
  assign wr_prg1   = cpu_wr && addr_hit(cpu_addr, MASK_PAGE, ADDR_PRG1);
  assign wr_prg2   = cpu_wr && addr_hit(cpu_addr, MASK_PAGE, ADDR_PRG2);
  assign wr_ram_on = cpu_wr && is_175 && addr_hit(cpu_addr, MASK_PAGE, ADDR_RAM_ON);
  assign wr_wp     = cpu_wr && is_163 && addr_hit(cpu_addr, MASK_PAGE, ADDR_WP);
  assign wr_lo     = cpu_wr && is_163 && hit_lo;
  assign wr_hi     = cpu_wr && is_163 && hit_hi;

  always_ff @(negedge m2) begin
    if (map_rst) begin
      for (int i = 0; i < CHR_BANKS; i++) chr_bank[i] <= CHR_BW'(i);
      for (int k = 0; k < 3; k++) prg_bank[k] <= 8'(k);
      prg_ram_on <= 1'b0;
      wp         <= 4'hF;
    end else if (ss_wr) begin
      if (ss_addr < CHR_N) begin
        chr_bank[ss_addr[CHR_IW-1:0]] <= CHR_BW'(cpu_dat);
      end else begin
        case (ss_addr)
          SS_PRG0:   prg_bank[0] <= cpu_dat;
          SS_PRG1:   prg_bank[1] <= cpu_dat;
          SS_PRG2:   prg_bank[2] <= cpu_dat;
          SS_RAM_ON: prg_ram_on  <= cpu_dat[0];
          SS_WP:     wp          <= cpu_dat[3:0];
          default:   ;
        endcase
      end
    end else begin
      if (wr_chr) chr_bank[cpu_addr[11 +: CHR_IW]] <= CHR_BW'(cpu_dat);
      if (wr_prg0) prg_bank[0] <= cpu_dat;
      if (wr_prg1) prg_bank[1] <= cpu_dat;
      if (wr_prg2) prg_bank[2] <= cpu_dat;
      if (wr_ram_on) prg_ram_on <= cpu_dat[0];
      // only the 01 key pattern unlocks; anything else re-protects all slices
      if (wr_wp) wp <= (cpu_dat[7:6] == 2'b01) ? cpu_dat[3:0] : 4'hF;
    end
  end

  logic [7:0] cnt_lo, cnt_hi;
  logic       ld_lo, ld_hi, ld_irq;
  assign ld_lo  = ss_wr && (ss_addr == SS_CNT_LO);
  assign ld_hi  = ss_wr && (ss_addr == SS_CNT_HI);
  assign ld_irq = ss_wr && (ss_addr == SS_IRQ);

  namco_irq_cnt #(.IRQ_W(IRQ_W)) u_irq (
    .m2      (m2),
    .map_rst (map_rst),
    .active  (is_163),
    .frz     (frz),
    .wr_lo   (wr_lo),
    .wr_hi   (wr_hi),
    .ld_lo   (ld_lo),
    .ld_hi   (ld_hi),
    .ld_irq  (ld_irq),
    .dat     (cpu_dat),
    .cnt_lo  (cnt_lo),
    .cnt_hi  (cnt_hi),
    .irq     (irq)
  );

  logic [PRG_BW-1:0] prg_sel;
  always_comb begin
    case (cpu_addr[14:13])
      2'd0:    prg_sel = prg_bank[0][PRG_BW-1:0];
      2'd1:    prg_sel = prg_bank[1][PRG_BW-1:0];
      2'd2:    prg_sel = prg_bank[2][PRG_BW-1:0];
      default: prg_sel = '1;
    endcase
  end
  assign prg_addr = {prg_sel, cpu_addr[12:0]};
  assign chr_addr = {chr_bank[ppu_addr[10 +: CHR_IW]], ppu_addr[9:0]};
  assign ciram_ce = !ppu_addr[13];

  always_comb begin
    if (is_340) begin
      case (prg_bank[0][7:6])
        2'd0:    ciram_a10 = 1'b0;
        2'd1:    ciram_a10 = ppu_addr[10];
        2'd2:    ciram_a10 = ppu_addr[11];
        default: ciram_a10 = 1'b1;
      endcase
    end else begin
      ciram_a10 = cfg_mir_v ? ppu_addr[10] : ppu_addr[11];
    end
  end

  assign rom_ce   = cpu_addr[15];
  assign ram_ce   = (cpu_addr[15:13] == 3'b011) && !is_340;
  assign ram_we   = ram_ce && !cpu_rw && (is_163 ? !wp[cpu_addr[12:11]] : prg_ram_on);
  assign reg_oe   = is_163 && cpu_rw && (hit_lo || hit_hi);
  assign reg_dout = cpu_addr[11] ? cnt_hi : cnt_lo;

`ifdef MAP_NAMCO_SS_EN
  always_comb begin
    ss_rdat = 8'hFF;
    if (ss_addr < CHR_N) begin
      ss_rdat = 8'(chr_bank[ss_addr[CHR_IW-1:0]]);
    end else begin
      case (ss_addr)
        SS_PRG0:   ss_rdat = prg_bank[0];
        SS_PRG1:   ss_rdat = prg_bank[1];
        SS_PRG2:   ss_rdat = prg_bank[2];
        SS_RAM_ON: ss_rdat = {7'd0, prg_ram_on};
        SS_WP:     ss_rdat = {4'd0, wp};
        SS_CNT_LO: ss_rdat = cnt_lo;
        SS_CNT_HI: ss_rdat = cnt_hi;
        SS_IRQ:    ss_rdat = {7'd0, irq};
        default:   ss_rdat = 8'hFF;
      endcase
    end
  end
`else
  assign ss_rdat = 8'hFF;
`endif

endmodule
